uart_rx_mmio: RTL and testbench
===============================

Name: uart_rx_mmio

Overview:
- UART receiver upstream of the data memory's memory-mapped status/data cells; produces the 2-bit USR (UART status) and 8-bit UDRR (UART data receive) values that data memory copies into its reserved cells every clock.
- Samples a serial rx line with 16x oversampling, assembles 8N1 frames (LSB first), and holds the byte and status until the CPU acknowledges by loading UDRR.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, with mid-bit sample at tick 7.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE), derived localparam, clocks per tick (minimum 1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line, asynchronous to clk, idle high.
- rd_ack  input  1  one-cycle pulse when the CPU loads the UDRR address; clears status.
- USR  output  2  [0] RXV: byte valid; [1] ERR: sticky frame/overrun (and parity) error.
- UDRR  output  8  last accepted received byte.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): USR=2'b00, UDRR=8'h00, busy=0, FSM=IDLE, tick counter and bit counter=0, both synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, giving 2 cycles of input latency.
- Tick generator: counter 0..DIV-1; emits a 1-cycle tick at DIV-1 and wraps to 0. Runs freely.
- FSM (sample counter sc 0..15 advances on tick; sc is reset on every state entry):
  - IDLE: rx_s==0 → START, sc=0.
  - START: at tick with sc==7, if rx_s==1 (glitch) → IDLE; else sc=0 → DATA, bit index=0.
  - DATA: every 16 ticks (sc==15 wrap), shift rx_s into shift[7] (LSB first, right-shift). After 8 bits → STOP.
  - STOP: at the 16th tick, sample rx_s.
    - rx_s==1: accept the byte → IDLE.
    - rx_s==0: frame error; set ERR, discard the byte → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE.
- Accept rule (same cycle as the stop sample):
  - If RXV==0, or rd_ack is high this cycle: UDRR<=shift, RXV<=1.
  - Else overrun: UDRR unchanged, byte discarded, ERR<=1.
- rd_ack:
  - Clears RXV and ERR on the next edge.
  - If it coincides with an accept, the accept wins: RXV=1 with the new byte, and ERR is cleared.
  - If it coincides with an error set, ERR=1.
- busy = (FSM != IDLE).
- Line low forever: one frame error, then the FSM stays in BREAK with no further ERR pulses.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: frame is 8E1. A PARITY state sits between DATA and STOP and samples one bit at mid-bit. If the XOR of 8 data bits and the parity bit is 1, the byte is discarded and ERR is set; the stop bit is still checked.
- Undefined: 8N1, no PARITY state. Frame length is 10 bits in 8N1 and 11 bits in 8E1.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding localparams: IDLE, START, DATA, PARITY, STOP, BREAK.
  - USR bit indices: USR_RXV=0, USR_ERR=1.
  - OVERSAMPLE and MID_SAMPLE=7 constants.
- Sub-module uart_baud_tick (parameter DIV; ports clk, rst, tick): the free-running tick counter, reusable by a future uart_tx_mmio.

Test Plan:
- Bench parameters: CLK_FREQ=1600000, BAUD=100000 → DIV=1, one bit = 16 clk.
- Frame 8'hA5, valid stop: USR=2'b01 and UDRR=8'hA5 within 16 clk after the stop-bit start. A rd_ack pulse then gives USR=2'b00 and UDRR still 8'hA5.
- 4-clk low glitch on idle rx: FSM returns to IDLE, USR stays 2'b00, no UDRR change, busy drops by clk 10.
- Frame 8'h3C with stop bit driven 0, rx released high 32 clk later: USR=2'b10, UDRR unchanged (8'h00 after reset), busy low after rx returns high.
- Overrun: send 8'h11 and 8'h22 with no rd_ack → UDRR=8'h11, USR=2'b11. Then rd_ack → USR=2'b00.
- rd_ack coincident with the stop-sample cycle of the second byte 8'h22 (first byte 8'h11 pending) → UDRR=8'h22, USR=2'b01.
- Assert rst=0 mid-DATA of a frame: outputs are cleared immediately (asynchronous). After release, the remaining bits are ignored until the next falling edge, and a following 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks feeding the memory-mapped USR/UDRR cells.
// State list includes PARITY, which is only reachable when UART_RX_PARITY_EN is defined.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   localparam int USR_RXV    = 0;
   localparam int USR_ERR    = 1;
   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   // Sample-counter compare values: mid-bit in START, last tick of a bit elsewhere.
   localparam logic [3:0] SC_MID  = 4'(MID_SAMPLE);
   localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
// Shared between the UART receiver and a future transmitter.
module uart_baud_tick #(
   parameter int DIV = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   // Count 0..DIV-1 and wrap; with DIV=1 the tick is asserted every cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_mmio.sv
// UART receiver producing the USR (status) and UDRR (data) values mirrored into
// data memory. 16x oversampling, LSB first, 8N1 by default; defining
// UART_RX_PARITY_EN switches to 8E1 with an even-parity check.
// The received byte and status are held until the CPU acknowledges with rd_ack.
module uart_rx_mmio
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rd_ack,
   output logic [1:0] USR,
   output logic [7:0] UDRR,
   output logic       busy
);

   localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;

   logic        tick;
   logic        rx_m;
   logic        rx_s;
   uart_state_t state;
   logic [3:0]  sc;
   logic [2:0]  bit_idx;
   logic [7:0]  shift;
   logic        par_err;
   logic        rxv;
   logic        err;
   logic [7:0]  udrr;

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
      end
   end

   // Data shift register: right-shift the mid-bit sample in at the end of each data bit.
   always_ff @(posedge clk) begin
      if (state == DATA && tick && sc == SC_LAST) begin
         shift <= {rx_s, shift[7:1]};
      end
   end

   // Frame FSM plus the held status/data; acceptance and errors override a same-cycle rd_ack clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         sc      <= '0;
         bit_idx <= '0;
         par_err <= 1'b0;
         rxv     <= 1'b0;
         err     <= 1'b0;
         udrr    <= 8'h00;
      end else begin
         if (rd_ack) begin
            rxv <= 1'b0;
            err <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  sc    <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (sc == SC_MID) begin
                     sc <= '0;
                     if (rx_s) begin
                        state <= IDLE;
                     end else begin
                        state   <= DATA;
                        bit_idx <= '0;
                        par_err <= 1'b0;
                     end
                  end else begin
                     sc <= sc + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (sc == SC_LAST) begin
                     sc      <= '0;
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end
                  end else begin
                     sc <= sc + 4'd1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (sc == SC_LAST) begin
                     sc      <= '0;
                     par_err <= ^{shift, rx_s};
                     state   <= STOP;
                  end else begin
                     sc <= sc + 4'd1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (sc == SC_LAST) begin
                     sc <= '0;
                     if (rx_s) begin
                        state <= IDLE;
                        if (par_err) begin
                           err <= 1'b1;
                        end else if (!rxv || rd_ack) begin
                           udrr <= shift;
                           rxv  <= 1'b1;
                        end else begin
                           err <= 1'b1;
                        end
                     end else begin
                        state <= BREAK;
                        err   <= 1'b1;
                     end
                  end else begin
                     sc <= sc + 4'd1;
                  end
               end
            end
            BREAK: begin
               if (rx_s) begin
                  state <= IDLE;
                  sc    <= '0;
               end
            end
            default: begin
               state <= IDLE;
               sc    <= '0;
            end
         endcase
      end
   end

   assign USR[USR_RXV] = rxv;
   assign USR[USR_ERR] = err;
   assign UDRR         = udrr;
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio at DIV=1 (one bit = 16 clk), default 8N1 build.
module tb_uart_rx_mmio;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx = 1'b1;
   logic       rd_ack = 1'b0;
   logic [1:0] USR;
   logic [7:0] UDRR;
   logic       busy;

   int total = 0;
   int bad = 0;

   // Reference model state: what the CPU should see in USR/UDRR.
   logic       exp_rxv = 1'b0;
   logic       exp_err = 1'b0;
   logic [7:0] exp_udrr = 8'h00;

   uart_rx_mmio #(.CLK_FREQ(1600000), .BAUD(100000)) dut (
      .clk    (clk),
      .rst    (rst),
      .rx     (rx),
      .rd_ack (rd_ack),
      .USR    (USR),
      .UDRR   (UDRR),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".usr"}, {6'b0, USR}, {6'b0, exp_err, exp_rxv});
      chk({tag, ".udrr"}, UDRR, exp_udrr);
      chk({tag, ".busy"}, {7'b0, busy}, 8'h00);
   endtask

   // Model of one completed frame; ack means rd_ack landed on the stop-sample cycle.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack);
      if (ack) begin
         exp_rxv = 1'b0;
         exp_err = 1'b0;
      end
      if (!stop_ok) begin
         exp_err = 1'b1;
      end else if (!exp_rxv) begin
         exp_udrr = b;
         exp_rxv  = 1'b1;
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic model_ack();
      exp_rxv = 1'b0;
      exp_err = 1'b0;
   endtask

   task automatic ack_pulse();
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      step();
   endtask

   // Drive one frame cycle by cycle. A bad stop bit keeps the line low 32 clk longer.
   // ack_cyc / rst_lo / rst_hi are cycle offsets from the start-bit edge (-1 = unused).
   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int ack_cyc,
                             input int rst_lo, input int rst_hi);
      int len;
      len = stop_ok ? 160 : 192;
      for (int c = 0; c < len; c++) begin
         if (c < 16) rx = 1'b0;
         else if (c < 144) rx = b[(c - 16) / 16];
         else rx = stop_ok;
         rd_ack = (c == ack_cyc);
         if (c == rst_hi) rst = 1'b1;
         if (c == rst_lo) begin
            rst = 1'b0;
            #1;
            chk("rst_async.usr", {6'b0, USR}, 8'h00);
            chk("rst_async.udrr", UDRR, 8'h00);
            chk("rst_async.busy", {7'b0, busy}, 8'h00);
         end
         step();
      end
      rd_ack = 1'b0;
      rx = 1'b1;
      repeat (8) step();
   endtask

   initial begin
      logic [7:0] rb;
      bit         rok;
      int         mode;

      // Reset state
      repeat (3) step();
      check_all("reset");
      rst = 1'b1;
      step();

      // Frame error: 0x3C with stop bit low, line released later
      send_frame(8'h3C, 1'b0, -1, -1, -1);
      model_frame(8'h3C, 1'b0, 1'b0);
      check_all("frame_err");
      ack_pulse();
      model_ack();
      check_all("frame_err_ack");

      // Good frame 0xA5 then acknowledge
      send_frame(8'hA5, 1'b1, -1, -1, -1);
      model_frame(8'hA5, 1'b1, 1'b0);
      check_all("a5");
      ack_pulse();
      model_ack();
      check_all("a5_ack");

      // 4-clk glitch on idle line
      rx = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c == 4) rx = 1'b1;
         step();
         if (c == 6) chk("glitch.busy_hi", {7'b0, busy}, 8'h01);
      end
      check_all("glitch");

      // Overrun: two bytes without acknowledge
      send_frame(8'h11, 1'b1, -1, -1, -1);
      model_frame(8'h11, 1'b1, 1'b0);
      send_frame(8'h22, 1'b1, -1, -1, -1);
      model_frame(8'h22, 1'b1, 1'b0);
      check_all("overrun");
      ack_pulse();
      model_ack();
      check_all("overrun_ack");

      // rd_ack on the stop-sample cycle of the second byte
      send_frame(8'h11, 1'b1, -1, -1, -1);
      model_frame(8'h11, 1'b1, 1'b0);
      check_all("coinc_first");
      send_frame(8'h22, 1'b1, 154, -1, -1);
      model_frame(8'h22, 1'b1, 1'b1);
      check_all("coinc_second");
      ack_pulse();
      model_ack();

      // Randomised frames, stop errors and acknowledge placements
      for (int i = 0; i < 10; i++) begin
         rb   = 8'($urandom);
         rok  = ($urandom_range(0, 3) != 0);
         mode = $urandom_range(0, 2);
         send_frame(rb, rok, (mode == 1) ? 154 : -1, -1, -1);
         model_frame(rb, rok, mode == 1);
         check_all("rand");
         if (mode == 2) begin
            ack_pulse();
            model_ack();
            check_all("rand_ack");
         end
      end

      // Asynchronous reset mid-DATA with a byte pending
      send_frame(8'h77, 1'b1, -1, -1, -1);
      send_frame(8'hE1, 1'b1, -1, 40, 100);
      exp_rxv = 1'b0;
      exp_err = 1'b0;
      exp_udrr = 8'h00;
      check_all("after_rst");
      send_frame(8'h5A, 1'b1, -1, -1, -1);
      model_frame(8'h5A, 1'b1, 1'b0);
      check_all("post_rst_5a");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
